data_mem_responder: RTL and testbench

//   Responder side of the core's data-memory port: serves combinational reads and byte/half/word stores

---
 rtl/dmem_pkg.sv | 12 +
 rtl/uart_tx.sv | 59 +++++
 rtl/data_mem_responder.sv | 96 +++++++++
 tb/tb_data_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  localparam logic [5:0] OFF_UART_TX = 6'd0;
  localparam logic [5:0] OFF_STATUS  = 6'd1;
  localparam logic [5:0] OFF_TIMER   = 6'd2;
  localparam int STS_EMPTY = 0;
  localparam int STS_FULL  = 1;
  localparam int STS_BUSY  = 2;
  localparam int STS_OVF   = 3;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer popping bytes from a valid/ready source
module uart_tx
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_state_e state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign ready = state == U_IDLE;
  assign busy = !ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= U_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      txd <= 1'b1;
    end else begin
      cnt <= (state == U_IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        U_IDLE: if (valid) begin
          state <= U_START;
          sh <= data;
          txd <= 1'b0;
        end
        U_START: if (bit_end) begin
          state <= U_DATA;
          txd <= sh[0];
          sh <= sh >> 1;
        end
        // bit_idx wraps back to 0 on the eighth bit, ready for the next frame
        U_DATA: if (bit_end) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state <= U_STOP;
            txd <= 1'b1;
          end else begin
            txd <= sh[0];
            sh <= sh >> 1;
          end
        end
        U_STOP: if (bit_end) state <= U_IDLE;
        default: state <= U_IDLE;
      endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus MMIO page (UART TX FIFO, status, timer)
// Optional timer register enabled by defining DMEM_TIMER_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_rd_addr,
  output logic [31:0] data_rd_data,
  input  logic [1:0]  data_wr,
  input  logic [31:0] data_wr_addr,
  input  logic [31:0] data_wr_data,
  output logic        uart_txd
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  logic [31:0] ram [DEPTH_WORDS];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [FW:0] wp, rp, count;
  logic [4:0] lvl;
  logic [31:0] status, timer, wd;
  logic [3:0] be;
  logic [5:0] rd_off, wr_off;
  size_e wr_sz;
  logic rd_ram, rd_mmio, wr_ram, wr_mmio, empty, full, ovf, push, accept, pop, tx_ready, tx_busy;
  assign wr_sz = size_e'(data_wr);
  assign rd_ram = data_rd_addr[31:AW+2] == '0;
  assign rd_mmio = data_rd_addr[31:8] == MMIO_BASE[31:8];
  assign wr_ram = wr_sz != SZ_NONE && data_wr_addr[31:AW+2] == '0;
  assign wr_mmio = wr_sz != SZ_NONE && data_wr_addr[31:8] == MMIO_BASE[31:8];
  assign rd_off = data_rd_addr[7:2];
  assign wr_off = data_wr_addr[7:2];
  assign be = wr_sz == SZ_BYTE ? 4'b0001 << data_wr_addr[1:0] :
              wr_sz == SZ_HALF ? (data_wr_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = wr_sz == SZ_BYTE ? {4{data_wr_data[7:0]}} :
              wr_sz == SZ_HALF ? {2{data_wr_data[15:0]}} : data_wr_data;
  always_ff @(posedge clk)
    if (wr_ram)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[data_wr_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  assign count = wp - rp;
  assign lvl = 5'(count);
  assign empty = wp == rp;
  assign full = count == (FW+1)'(FIFO_DEPTH);
  assign push = wr_mmio && wr_off == OFF_UART_TX;
  assign pop = !empty && tx_ready;
  // a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign accept = push && (!full || pop);
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      ovf <= 1'b0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && !accept) ovf <= 1'b1;
      else if (wr_mmio && wr_off == OFF_STATUS) ovf <= 1'b0;
    end
  always_ff @(posedge clk)
    if (accept) fifo[wp[FW-1:0]] <= data_wr_data[7:0];
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .valid(!empty),
    .data(fifo[rp[FW-1:0]]),
    .ready(tx_ready),
    .busy(tx_busy),
    .txd(uart_txd)
  );
`ifdef DMEM_TIMER_EN
  always_ff @(posedge clk)
    if (!rst_n) timer <= '0;
    else timer <= (wr_mmio && wr_off == OFF_TIMER) ? data_wr_data : timer + 1'b1;
`else
  assign timer = '0;
`endif
  always_comb begin
    status = '0;
    status[STS_EMPTY] = empty;
    status[STS_FULL] = full;
    status[STS_BUSY] = tx_busy;
    status[STS_OVF] = ovf;
    status[7:4] = lvl[3:0];
  end
  assign data_rd_data = rd_ram ? ram[data_rd_addr[AW+1:2]] :
                        rd_mmio ? (rd_off == OFF_STATUS ? status :
                                   rd_off == OFF_TIMER ? timer : '0) : '0;
  logic unused_ok;
  assign unused_ok = &{1'b0, data_rd_addr[1:0], lvl[4]};
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench with byte-level RAM model and UART receiver
module tb_data_mem_responder;
  localparam int CPB = 4;
  localparam logic [31:0] MB = 32'hFFFF_FF00;
  localparam logic [31:0] UTX = MB;
  localparam logic [31:0] STS = MB + 32'h4;
  localparam logic [31:0] TMR = MB + 32'h8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] data_rd_addr = '0;
  logic [31:0] data_rd_data;
  logic [1:0] data_wr = '0;
  logic [31:0] data_wr_addr = '0;
  logic [31:0] data_wr_data = '0;
  logic uart_txd;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mdl [256];
  logic [7:0] rx_q [$];
  logic [7:0] rx_b;
  int rx_ferr = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_rd_addr(data_rd_addr),
    .data_rd_data(data_rd_data),
    .data_wr(data_wr),
    .data_wr_addr(data_wr_addr),
    .data_wr_data(data_wr_data),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  // independent UART receiver: samples mid-bit on the falling clock edge
  initial forever begin
    @(negedge clk);
    if (uart_txd === 1'b0) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_b[i] = uart_txd;
      end
      repeat (CPB) @(negedge clk);
      if (uart_txd === 1'b1) rx_q.push_back(rx_b);
      else rx_ferr++;
    end
  end

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    data_wr = sz;
    data_wr_addr = a;
    data_wr_data = d;
    @(posedge clk);
    #1;
    data_wr = 2'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_rd_addr = a;
    #1;
    d = data_rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (uart_txd !== 1'b1) begin n_err++; $display("FAIL reset_txd got %b want 1", uart_txd); end
    rd(STS, v);
    n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL reset_status got %h want 00000001", v); end
    rd(TMR, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_timer got %h want 00000000", v); end
    rst_n = 1'b1;
  endtask

  task automatic test_ram_directed;
    logic [31:0] v;
    st(2'd3, 32'h10, 32'h1122_3344);
    st(2'd1, 32'h13, 32'hAB);
    rd(32'h10, v);
    n_cmp++;
    if (v !== 32'hAB22_3344) begin n_err++; $display("FAIL sb_lane3 got %h want ab223344", v); end
    rd(32'h12, v);
    n_cmp++;
    if (v !== 32'hAB22_3344) begin n_err++; $display("FAIL read_unaligned got %h want ab223344", v); end
    st(2'd3, 32'h20, 32'h0);
    st(2'd2, 32'h23, 32'hBEEF);
    rd(32'h20, v);
    n_cmp++;
    if (v !== 32'hBEEF_0000) begin n_err++; $display("FAIL sh_upper got %h want beef0000", v); end
    st(2'd3, 32'h1010, 32'hDEAD_BEEF);
    rd(32'h10, v);
    n_cmp++;
    if (v !== 32'hAB22_3344) begin n_err++; $display("FAIL unmapped_alias got %h want ab223344", v); end
    rd(32'h1010, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h want 0", v); end
    rd(UTX, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL uart_tx_read got %h want 0", v); end
    rd(MB + 32'hC, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL mmio_hole_read got %h want 0", v); end
  endtask

  task automatic test_ram_random;
    logic [31:0] d, ra, wa, exp;
    int sz, a, n, b;
    logic unm;
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      st(2'd3, 32'(4 * w), d);
      for (int j = 0; j < 4; j++) mdl[4*w+j] = d[8*j +: 8];
    end
    for (int it = 0; it < 300; it++) begin
      sz = $urandom_range(1, 3);
      a = $urandom_range(0, 255);
      d = $urandom;
      unm = $urandom_range(0, 7) == 0;
      wa = unm ? 32'h1000 + 32'(a) : 32'(a);
      ra = ($urandom_range(0, 3) == 0) ? 32'(a) : 32'($urandom_range(0, 255));
      data_wr = 2'(sz);
      data_wr_addr = wa;
      data_wr_data = d;
      data_rd_addr = ra;
      #1;
      b = int'(ra) & ~3;
      exp = {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
      n_cmp++;
      if (data_rd_data !== exp) begin
        n_err++;
        $display("FAIL ram_random it=%0d addr=%h got %h want %h", it, ra, data_rd_data, exp);
      end
      if (!unm) begin
        n = 1 << (sz - 1);
        b = a & ~(n - 1);
        for (int j = 0; j < n; j++) mdl[b+j] = d[8*j +: 8];
      end
      @(posedge clk);
      #1;
      data_wr = 2'd0;
    end
    for (int w = 0; w < 64; w++) begin
      rd(32'(4 * w), d);
      exp = {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
      n_cmp++;
      if (d !== exp) begin n_err++; $display("FAIL ram_sweep word=%0d got %h want %h", w, d, exp); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_uart_frame;
    logic [31:0] v;
    logic e;
    int bi;
    rx_q.delete();
    st(2'd1, UTX, 32'h55);
    n_cmp++;
    if (uart_txd !== 1'b1) begin n_err++; $display("FAIL frame_pre got %b want 1", uart_txd); end
    @(posedge clk);
    #1;
    for (int k = 0; k < 10 * CPB; k++) begin
      bi = k / CPB;
      e = bi == 0 ? 1'b0 : bi == 9 ? 1'b1 : 1'((8'h55 >> (bi - 1)) & 8'h1);
      n_cmp++;
      if (uart_txd !== e) begin n_err++; $display("FAIL frame_bit cycle=%0d got %b want %b", k, uart_txd, e); end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (uart_txd !== 1'b1) begin n_err++; $display("FAIL frame_idle got %b want 1", uart_txd); end
    rd(STS, v);
    n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL frame_status got %h want 00000001", v); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h55)
      begin n_err++; $display("FAIL frame_rx size=%0d want 1 byte 55", rx_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0] exp_q [$];
    logic [7:0] b;
    int i;
    rx_q.delete();
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      if (k < 9) exp_q.push_back(b);
      data_wr = 2'd3;
      data_wr_addr = UTX;
      data_wr_data = {24'($urandom), b};
      @(posedge clk);
      #1;
    end
    data_wr = 2'd0;
    rd(STS, v);
    n_cmp++;
    if (v !== 32'h8E) begin n_err++; $display("FAIL overflow_status got %h want 0000008e", v); end
    st(2'd2, STS, 32'h0);
    rd(STS, v);
    n_cmp++;
    if (v !== 32'h86) begin n_err++; $display("FAIL ovf_clear got %h want 00000086", v); end
    // wait for the idle cycle between frames, then push while full as the pop happens
    for (i = 0; i < 200; i++) begin
      rd(STS, v);
      if (v === 32'h82) break;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (v !== 32'h82) begin n_err++; $display("FAIL wait_gap got %h want 00000082", v); end
    b = 8'($urandom);
    exp_q.push_back(b);
    st(2'd1, UTX, {24'h0, b});
    rd(STS, v);
    n_cmp++;
    if (v !== 32'h86) begin n_err++; $display("FAIL full_push_pop got %h want 00000086", v); end
    for (i = 0; i < 600; i++) begin
      rd(STS, v);
      if (rx_q.size() >= exp_q.size() && v === 32'h1) break;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (rx_q.size() !== exp_q.size() || v !== 32'h1)
      begin n_err++; $display("FAIL drain rx=%0d status=%h want %0d and 00000001", rx_q.size(), v, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      n_cmp++;
      if (rx_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rx_byte %0d got %h want %h", k, rx_q[k], exp_q[k]); end
    end
    n_cmp++;
    if (rx_ferr !== 0) begin n_err++; $display("FAIL framing_errors got %0d want 0", rx_ferr); end
  endtask

  task automatic test_timer;
    logic [31:0] v, base, exp;
    int k;
    st(2'd3, TMR, 32'hFFFF_FFFE);
    for (int c = 0; c < 3; c++) begin
`ifdef DMEM_TIMER_EN
      exp = 32'hFFFF_FFFE + 32'(c);
`else
      exp = 32'h0;
`endif
      rd(TMR, v);
      n_cmp++;
      if (v !== exp) begin n_err++; $display("FAIL timer_wrap c=%0d got %h want %h", c, v, exp); end
      @(posedge clk);
      #1;
    end
    for (int r = 0; r < 4; r++) begin
      base = $urandom;
      k = $urandom_range(0, 20);
      st(2'd1, TMR, base);
      repeat (k) @(posedge clk);
      #1;
`ifdef DMEM_TIMER_EN
      exp = base + 32'(k);
`else
      exp = 32'h0;
`endif
      rd(TMR, v);
      n_cmp++;
      if (v !== exp) begin n_err++; $display("FAIL timer_load r=%0d got %h want %h", r, v, exp); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    int highs;
    st(2'd1, UTX, 32'hA5);
    st(2'd1, UTX, 32'h3C);
    st(2'd1, UTX, 32'h77);
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (uart_txd !== 1'b1) begin n_err++; $display("FAIL abort_txd got %b want 1", uart_txd); end
    rd(STS, v);
    n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL abort_status got %h want 00000001", v); end
    rd(32'h8000_0000, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL abort_unmapped got %h want 0", v); end
    rst_n = 1'b1;
    highs = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (uart_txd === 1'b1) highs++;
    end
    n_cmp++;
    if (highs !== 60) begin n_err++; $display("FAIL flushed_idle got %0d high cycles want 60", highs); end
    rx_q.delete();
    rx_ferr = 0;
  endtask

  initial begin
    test_reset();
    test_ram_directed();
    test_ram_random();
    test_uart_frame();
    test_back_to_back();
    test_timer();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
